// File: rtl/alu_bist_ctrl_if.sv
// ALU-side bus between the BIST controller (master) and the ALU plus its test environment (slave).
// Shared by alu_bist_ctrl, which honours the optional ALU_BIST_ILLEGAL_OP_EN build macro.
interface alu_bist_ctrl_if;
    logic        start;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        busy;
    logic        done;
    logic        pass;
    logic [31:0] signature;

    modport master (
        input  start, alu_result, alu_zero,
        output alu_a, alu_b, alu_control, busy, done, pass, signature
    );

    modport slave (
        output start, alu_result, alu_zero,
        input  alu_a, alu_b, alu_control, busy, done, pass, signature
    );
endinterface

// File: rtl/alu_bist_ctrl.sv
// ALU BIST controller: LFSR operands per opcode, MISR compaction, golden-signature compare.
// Define ALU_BIST_ILLEGAL_OP_EN to append the unimplemented opcode 4'b1111 to the sweep.
module alu_bist_ctrl #(
    parameter int unsigned NUM_VECTORS = 64,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_bist_ctrl_if.master bus
);
`ifdef ALU_BIST_ILLEGAL_OP_EN
    localparam int unsigned NUM_OPS = 9;
`else
    localparam int unsigned NUM_OPS = 8;
`endif
    localparam int unsigned VW        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int unsigned OW        = 4;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] B_MASK    = 32'h5A5A_5A5A;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CMP, S_DONE} state_e;

    state_e        state_q;
    logic [31:0]   lfsr_q;
    logic [31:0]   sig_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic [3:0]    ctrl_q;
    logic [VW-1:0] vec_q;
    logic [OW-1:0] op_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;

    logic [31:0]   lfsr_d;
    logic [31:0]   sig_d;
    logic [31:0]   b_d;
    logic [VW-1:0] vec_d;
    logic [OW-1:0] op_d;
    logic          last_vec;
    logic          last_op;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        lfsr_step = {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'h0);
    endfunction

    // Sweep index to ALU opcode; 0111 is skipped by the ALU's opcode map.
    function automatic logic [3:0] opcode(input logic [OW-1:0] idx);
        case (idx)
            4'd7:    opcode = 4'b1000;
            4'd8:    opcode = 4'b1111;
            default: opcode = idx;
        endcase
    endfunction

    always_comb begin
        lfsr_d   = lfsr_step(lfsr_q);
        sig_d    = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0)
                 ^ bus.alu_result ^ {31'b0, bus.alu_zero};
        last_vec = (vec_q == VW'(NUM_VECTORS - 1));
        last_op  = (op_q == OW'(NUM_OPS - 1));
        vec_d    = last_vec ? '0 : vec_q + 1'b1;
        op_d     = last_vec ? op_q + 1'b1 : op_q;
        // Vector 0 of each opcode uses B=A so SUB and XOR must raise zero.
        b_d      = (vec_d == '0) ? lfsr_q : ({lfsr_q[15:0], lfsr_q[31:16]} ^ B_MASK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            sig_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            vec_q   <= '0;
            op_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        a_q     <= LFSR_SEED;
                        b_q     <= LFSR_SEED;
                        ctrl_q  <= opcode('0);
                        lfsr_q  <= lfsr_step(LFSR_SEED);
                        vec_q   <= '0;
                        op_q    <= '0;
                        sig_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    sig_q <= sig_d;
                    if (last_vec && last_op) begin
                        state_q <= S_CMP;
                        a_q     <= '0;
                        b_q     <= '0;
                        ctrl_q  <= '0;
                    end else begin
                        a_q    <= lfsr_q;
                        b_q    <= b_d;
                        ctrl_q <= opcode(op_d);
                        vec_q  <= vec_d;
                        op_q   <= op_d;
                        lfsr_q <= lfsr_d;
                    end
                end
                S_CMP: begin
                    pass_q  <= (sig_q == GOLDEN_SIG);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_control = ctrl_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.signature   = sig_q;
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl with a behavioural ALU, fault injection and a vector-list reference model.
// Follows ALU_BIST_ILLEGAL_OP_EN so the model sweeps the same opcode list as the build.
`timescale 1ns/1ps
module tb_alu_bist_ctrl;
    localparam int NV = 4;
`ifdef ALU_BIST_ILLEGAL_OP_EN
    localparam int NOPS = 9;
`else
    localparam int NOPS = 8;
`endif
    localparam int          NRUN    = NOPS * NV;
    localparam logic [31:0] SEED    = 32'hACE1_2468;
    localparam logic [35:0] OP_LIST = {4'hF, 4'h8, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'h0:    alu_ref = a + b;
            4'h1:    alu_ref = a - b;
            4'h2:    alu_ref = a & b;
            4'h3:    alu_ref = a | b;
            4'h4:    alu_ref = a ^ b;
            4'h5:    alu_ref = a << b[4:0];
            4'h6:    alu_ref = a >> b[4:0];
            4'h8:    alu_ref = a;
            default: alu_ref = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        lfsr_next = (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [31:0] operand_b(input int v, input logic [31:0] a);
        operand_b = (v == 0) ? a : ({a[15:0], a[31:16]} ^ 32'h5A5A_5A5A);
    endfunction

    // Expected final signature for a whole run, with an optional ALU fault (1: result bit stuck 0, 2: zero inverted on SUB v0).
    function automatic logic [31:0] ref_sig(input int fault, input int bitk);
        logic [31:0] s, l, a, b, r;
        logic        z;
        s = 32'h0;
        l = SEED;
        for (int o = 0; o < NOPS; o++) begin
            for (int v = 0; v < NV; v++) begin
                a = l;
                b = operand_b(v, a);
                r = alu_ref(OP_LIST[o*4 +: 4], a, b);
                z = (r == 32'h0);
                if (fault == 1) r[bitk[4:0]] = 1'b0;
                if (fault == 2 && o == 1 && v == 0) z = ~z;
                s = ((s << 1) ^ (s[31] ? 32'h04C1_1DB7 : 32'h0)) ^ r ^ {31'b0, z};
                l = lfsr_next(l);
            end
        end
        ref_sig = s;
    endfunction

    localparam logic [31:0] GOLDEN = ref_sig(0, 0);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    alu_bist_ctrl_if bus();

    alu_bist_ctrl #(.NUM_VECTORS(NV), .LFSR_SEED(SEED), .GOLDEN_SIG(GOLDEN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int fault_mode = 0;
    int fault_bit  = 0;
    logic [31:0] alu_raw;

    always_comb begin
        alu_raw        = alu_ref(bus.alu_control, bus.alu_a, bus.alu_b);
        bus.alu_result = alu_raw;
        if (fault_mode == 1) bus.alu_result[fault_bit[4:0]] = 1'b0;
        bus.alu_zero = (alu_raw == 32'h0);
        if (fault_mode == 2 && bus.alu_control == 4'h1 && bus.alu_a == bus.alu_b)
            bus.alu_zero = ~bus.alu_zero;
    end

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_a [NRUN];
    logic [31:0] exp_b [NRUN];
    logic [3:0]  exp_c [NRUN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_sig"},  bus.signature, 0);
        check({tag, "_a"},    bus.alu_a, 0);
        check({tag, "_b"},    bus.alu_b, 0);
        check({tag, "_ctrl"}, bus.alu_control, 0);
    endtask

    // Entered #1 after an edge with the DUT in IDLE or DONE; returns once DONE has been held one cycle.
    task automatic do_run(input int glitch_at, output logic [31:0] sig_o, output logic pass_o, output int busy_o);
        int cyc;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("start_done_drop", bus.done, 0);
        check("start_pass_drop", bus.pass, 0);
        check("start_sig_clear", bus.signature, 0);
        busy_o = 0;
        cyc = 0;
        while (!bus.done && cyc < 4 * NRUN) begin
            if (bus.busy) busy_o++;
            if (cyc < NRUN) begin
                check("vec_a", bus.alu_a, exp_a[cyc]);
                check("vec_b", bus.alu_b, exp_b[cyc]);
                check("vec_ctrl", bus.alu_control, exp_c[cyc]);
            end else if (cyc == NRUN) begin
                check("cmp_ports_idle", {bus.alu_a ^ bus.alu_b, 28'h0, bus.alu_control} | bus.alu_a, 0);
            end
            bus.start = (cyc == glitch_at);
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check("run_reaches_done", bus.done, 1);
        sig_o  = bus.signature;
        pass_o = bus.pass;
        @(posedge clk); #1;
        check("sig_frozen", bus.signature, sig_o);
        check("pass_held", bus.pass, pass_o);
    endtask

    typedef struct {
        int   fault;
        int   bitk;      // -1: random bit
        int   glitch;    // -1: none, -2: random cycle within the run
        logic exp_pass;
    } row_t;

    initial begin
        row_t        tbl [7];
        logic [31:0] l, sig, exp_sig;
        logic        pass;
        int          busy_n, g, abort_at, cyc;

        l = SEED;
        for (int o = 0; o < NOPS; o++) begin
            for (int v = 0; v < NV; v++) begin
                exp_a[o*NV + v] = l;
                exp_b[o*NV + v] = operand_b(v, l);
                exp_c[o*NV + v] = OP_LIST[o*4 +: 4];
                l = lfsr_next(l);
            end
        end

        tbl[0] = '{0,  0, -1, 1'b1};
        tbl[1] = '{1,  0, -1, 1'b0};
        tbl[2] = '{2,  0, -1, 1'b0};
        tbl[3] = '{0,  0,  5, 1'b1};
        tbl[4] = '{0,  0, -2, 1'b1};
        tbl[5] = '{1, -1, -1, 1'b0};
        tbl[6] = '{0,  0, -1, 1'b1};

        bus.start = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        bus.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", bus.busy, 0);

        for (int i = 0; i < 7; i++) begin
            fault_mode = tbl[i].fault;
            fault_bit  = (tbl[i].bitk < 0) ? int'($urandom_range(0, 31)) : tbl[i].bitk;
            g = (tbl[i].glitch == -2) ? int'($urandom_range(0, NRUN)) : tbl[i].glitch;
            do_run(g, sig, pass, busy_n);
            exp_sig = ref_sig(fault_mode, fault_bit);
            check("run_sig", sig, exp_sig);
            check("run_pass", pass, tbl[i].exp_pass);
            check("run_busy_len", busy_n, NRUN + 1);
            $display("run %0d: fault=%0d bit=%0d glitch=%0d sig=%h pass=%0b busy=%0d",
                     i, fault_mode, fault_bit, g, sig, pass, busy_n);
            fault_mode = 0;
        end

        for (int k = 0; k < 3; k++) begin
            abort_at = (k == 0) ? 10 : int'($urandom_range(0, NRUN));
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            repeat (abort_at) @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            check_all_zero("midrun_reset");
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("midrun_stays_idle", bus.busy, 0);
            do_run(-1, sig, pass, busy_n);
            check("rerun_sig", sig, GOLDEN);
            check("rerun_pass", pass, 1);
            $display("abort at vector %0d: rerun sig=%h pass=%0b", abort_at, sig, pass);
        end

        bus.start = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 4 * NRUN) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_done", bus.done, 1);
        check("b2b_done_not_busy", bus.busy, 0);
        @(posedge clk); #1;
        check("b2b_restart_busy", bus.busy, 1);
        check("b2b_restart_done", bus.done, 0);
        check("b2b_restart_sig", bus.signature, 0);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 4 * NRUN) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_sig", bus.signature, GOLDEN);
        check("b2b_pass", bus.pass, 1);
        $display("back-to-back run: sig=%h pass=%0b", bus.signature, bus.pass);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
Built-in self-test controller that drives the ALU's operand and control inputs and checks its result/zero outputs, the opposite end of the ALU interface from the ALU itself.
- Steps through every supported ALU opcode with pseudo-random operands from a 32-bit LFSR.
- Compresses each result and zero flag into a 32-bit MISR signature.
- At the end of the run, compares the signature against a golden value.
- Sits beside the ALU behind a test mux. It is used for bring-up and manufacturing test.

Parameters:
- NUM_VECTORS, 64, number of operand vectors applied per opcode. Legal range 2..1024.
- LFSR_SEED, 32'hACE1_2468, LFSR value loaded at run start. Must be nonzero.
- GOLDEN_SIG, 32'h0000_0000, expected final signature. It is set per build from the team's golden model.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  run request, sampled only in IDLE or DONE.
- alu_a  output  32  operand A to ALU, registered.
- alu_b  output  32  operand B to ALU, registered.
- alu_control  output  4  opcode to ALU, registered.
- alu_result  input  32  ALU result (combinational from the driven inputs).
- alu_zero  input  1  ALU zero flag.
- busy  output  1  high during RUN and CMP.
- done  output  1  high in DONE.
- pass  output  1  signature match, valid while done=1.
- signature  output  32  current MISR value.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is synchronous and active-low.
  - When rst_n=0 at a rising edge, the state goes to IDLE.
  - All outputs go to 0, including alu_a, alu_b, alu_control, busy, done, pass and signature.
  - The LFSR loads LFSR_SEED and all counters clear.
  - A reset in any state, including mid-RUN, aborts the run with no other side effect.
- Opcode list, in order: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 1000 PASS. NUM_OPS=8.
- LFSR: 32-bit Galois, shift right, tap mask 32'h8020_0003. It advances once per applied vector and is never reseeded between opcodes.
- Vector generation, with v the vector index within the current opcode:
  - alu_a = LFSR.
  - If v==0: alu_b = alu_a, forcing zero=1 on SUB and XOR.
  - Otherwise: alu_b = {LFSR[15:0], LFSR[31:16]} ^ 32'h5A5A_5A5A.
- MISR update, applied at each RUN edge:
  - sig_next = {sig[30:0],1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 0) ^ alu_result ^ {31'b0, alu_zero}.
- FSM states: IDLE, RUN, CMP, DONE.
  - IDLE→RUN when start=1. On that edge:
    - Load vector 0 of opcode 0 onto the ALU ports.
    - Clear sig.
    - Set busy=1.
  - RUN: each edge folds the currently driven vector's alu_result/alu_zero into sig, then presents the next vector.
    - The opcode advances after NUM_VECTORS vectors.
    - After the last vector (NUM_OPS*NUM_VECTORS edges in RUN), go to CMP and return alu_a, alu_b and alu_control to 0.
  - CMP: one cycle. pass <= (sig == GOLDEN_SIG). Then go to DONE.
  - DONE: busy=0, done=1, pass held.
    - DONE→RUN when start=1. This is a restart with identical reinitialisation: done and pass drop on that edge.
- start is ignored during RUN and CMP. Holding it high continuously produces back-to-back runs with one DONE cycle between them.
- busy is high for exactly NUM_OPS*NUM_VECTORS+1 cycles per run.
- signature is visible live and is frozen outside RUN.

Optional Feature:
- Macro: ALU_BIST_ILLEGAL_OP_EN.
- When defined, a 9th opcode 4'b1111 (unimplemented) is appended to the opcode list, so NUM_OPS=9. Its vectors are folded into the MISR like every other opcode, so the ALU must return result 0 / zero 1 on it for the signature to match.
- When undefined, NUM_OPS=8 and 4'b1111 is never driven.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, pass=0, signature=0, alu_a=alu_b=0, alu_control=0. The FSM stays in IDLE while rst_n=0.
2. Sequencing: NUM_VECTORS=4, pulse start → first RUN cycle shows alu_a=alu_b=32'hACE1_2468 and alu_control=0. alu_control follows 0,1,2,3,4,5,6,8, each held for 4 cycles. busy is high for 33 cycles, then done=1.
3. Golden pass: real ALU attached, GOLDEN_SIG taken from the reference model for the default parameters → done=1, pass=1, signature==GOLDEN_SIG.
4. Fault detect: force alu_result[0] stuck at 0 → done=1, pass=0, signature≠GOLDEN_SIG. Likewise, inverting alu_zero only on SUB v==0 gives pass=0.
5. Start handling: pulse start during RUN → no effect, busy length unchanged. Pulse start in DONE → done drops on the next edge, signature clears, and the new run reproduces the identical signature.
6. Reset mid-run: rst_n=0 at vector 10 → next edge returns to IDLE with all outputs 0. A subsequent start gives the same final signature as an uninterrupted run.
